router_fifo: RTL and testbench

- Per-destination packet buffer of the 1x3 router, directly downstream of router_sync.
- Three instances are built, one per output port.
- Each instance is written when its router_sync write_enb bit is set and read by the external client. It reports full/empty back to router_sync, which derives vld_out_x and fifo_full from them.
- Tags each stored byte with a header marker so the read side can track packet boundaries and idle the output after the parity byte.

---
 rtl/router_fifo.sv | 66 ++++++
 tb/tb_router_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination packet buffer for the 1x3 router. Each entry carries a header
// marker so the read side can count the packet down and idle data_out after parity.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [6:0]       pkt_cnt;
  logic             do_wr, do_rd, flush;
  logic [WIDTH:0]   rd_entry;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  assign flush    = reset | soft_reset;
  assign do_wr    = write_enb & ~full;
  assign do_rd    = read_enb & ~empty;
  assign rd_entry = mem[rd_ptr[PTR_W-1:0]];

  // Storage is never cleared; a flush only drops the write presented that cycle.
  always_ff @(posedge clock) begin
    if (!flush && do_wr)
      mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_entry[WIDTH-1:0];
        // Header byte carries payload length in [7:2]; +1 accounts for parity.
        if (rd_entry[WIDTH])
          pkt_cnt <= 7'(rd_entry[7:2]) + 7'd1;
        else if (pkt_cnt != 7'd0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end else if (pkt_cnt == 7'd0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Randomized + directed bench for router_fifo against a queue-based packet model.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full, empty;

  int total = 0;
  int bad = 0;

  router_fifo #(.WIDTH(8), .DEPTH(16), .PTR_W(4)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a packet countdown.
  logic [8:0] q[$];
  logic [8:0] m_e;
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_full, m_empty, m_rd, m_wr;
  bit         chk_en = 1'b0;

  always @(posedge clock) begin
    m_full  = (q.size() == 16);
    m_empty = (q.size() == 0);
    if (reset || soft_reset) begin
      q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
      chk_en = 1'b1;
    end else begin
      m_rd = read_enb && !m_empty;
      m_wr = write_enb && !m_full;
      if (m_rd) begin
        m_e    = q.pop_front();
        m_dout = m_e[7:0];
        if (m_e[8]) m_cnt = int'(m_e[7:2]) + 1;
        else if (m_cnt != 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (m_wr) q.push_back({lfd_state, data_in});
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("full", 32'(full), 32'(q.size() == 16));
      check("empty", 32'(empty), 32'(q.size() == 0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0; reset = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    write_enb = 1; read_enb = 0; data_in = d; lfd_state = lfd;
    tick();
    idle();
  endtask

  task automatic rd_expect(input string name, input logic [7:0] exp);
    write_enb = 0; read_enb = 1;
    tick();
    idle();
    check(name, 32'(data_out), 32'(exp));
  endtask

  logic [7:0] pkt[5];

  initial begin
    // Reset held with a write pending: nothing must be stored.
    write_enb = 1; data_in = 8'h77;
    tick(); tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    idle(); tick();
    check("rst_nothing_stored", 32'(empty), 32'd1);

    // Fill then overflow.
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    wr(8'hAA, 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      write_enb = 0; read_enb = 1;
      tick();
      check("fill_order", 32'(data_out), 32'(8'h10 + i));
    end
    idle(); tick();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_idle", 32'(data_out), 32'd0);

    // Packet boundary: header 0x0D => 3 payload + parity.
    pkt[0] = 8'h0D; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt[4] = 8'h5A;
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    for (int i = 0; i < 5; i++) begin
      read_enb = 1;
      tick();
      check("pkt_byte", 32'(data_out), 32'(pkt[i]));
    end
    idle(); tick();
    check("pkt_idle", 32'(data_out), 32'd0);

    // Steady-state simultaneous read/write across pointer wrap.
    for (int i = 0; i < 8; i++) wr(8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      write_enb = 1; read_enb = 1; data_in = 8'($urandom);
      tick();
    end
    idle();
    check("rw_not_empty", 32'(empty), 32'd0);
    check("rw_not_full", 32'(full), 32'd0);
    read_enb = 1;
    for (int i = 0; i < 8; i++) tick();
    idle(); tick();
    check("rw_drained", 32'(empty), 32'd1);

    // Empty with R+W: only the write lands.
    write_enb = 1; read_enb = 1; data_in = 8'h3C;
    tick(); idle();
    check("erw_empty", 32'(empty), 32'd0);
    check("erw_dout", 32'(data_out), 32'd0);
    rd_expect("erw_read", 8'h3C);
    tick();

    // Full with R+W: only the read lands, written byte lost.
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1'b0);
    write_enb = 1; read_enb = 1; data_in = 8'hEE;
    tick(); idle();
    check("frw_full", 32'(full), 32'd0);
    check("frw_dout", 32'(data_out), 32'h40);
    read_enb = 1;
    for (int i = 0; i < 15; i++) tick();
    idle(); tick();
    check("frw_empty", 32'(empty), 32'd1);

    // Soft reset mid-packet, with a read and write presented that cycle.
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    read_enb = 1;
    tick(); tick(); tick();
    check("srst_pre", 32'(data_out), 32'h02);
    soft_reset = 1; write_enb = 1; data_in = 8'h99;
    tick(); idle();
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_dout", 32'(data_out), 32'd0);
    wr(8'h05, 1'b1); wr(8'hA1, 1'b0); wr(8'hA2, 1'b0);
    read_enb = 1;
    tick(); check("srst_hdr", 32'(data_out), 32'h05);
    tick(); check("srst_b1", 32'(data_out), 32'hA1);
    tick(); check("srst_b2", 32'(data_out), 32'hA2);
    idle(); tick();
    check("srst_idle", 32'(data_out), 32'd0);

    // Random traffic, occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      write_enb  = ($urandom_range(0, 3) != 0);
      read_enb   = ($urandom_range(0, 2) != 0);
      lfd_state  = ($urandom_range(0, 7) == 0);
      data_in    = 8'($urandom);
      soft_reset = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 255) == 0);
      tick();
    end
    idle(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
